// File: rtl/uart_debug_tx.sv
// Generic queue: registered occupancy count drives full/empty, pointers wrap naturally.
// Latency: a pushed word is visible on rd_dat the cycle after the push edge.
// Backpressure: wr_rdy low while count == DEPTH; rd_vld low while empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != (AW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_vld & rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// UART debug transmitter: queues 9-bit frames, sends start, 9 bits LSB first, stop(s); DBG_TX_PARITY_EN replaces bit 8 with even parity of [7:0].
// Latency: a frame accepted into an empty queue with debug=1 drives tx low one cycle later.
// Backpressure: frame_ready low while the queue holds FIFO_DEPTH frames; a refused frame pulses overflow.
module uart_debug_tx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        debug,
    input  logic [8:0]                  frame,
    input  logic                        frame_valid,
    output logic                        frame_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int             BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;
    logic [8:0]    head;
    logic [8:0]    tx_word;
    logic          head_vld;
    logic          baud_end;
    logic          stop_end;
    logic          load;

    fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (frame_valid),
        .wr_rdy (frame_ready),
        .wr_dat (frame),
        .rd_vld (head_vld),
        .rd_rdy (load),
        .rd_dat (head),
        .count  (fifo_count)
    );

`ifdef DBG_TX_PARITY_EN
    assign tx_word = {^head[7:0], head[7:0]};
`else
    assign tx_word = head;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign stop_end = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);
    // The pop happens on the same edge that drives the start bit, so back-to-back frames have no idle gap.
    assign load     = debug && head_vld && ((state == IDLE) || stop_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= frame_valid & ~frame_ready;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (load) begin
                        shift <= tx_word;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[8:1]};
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (load) begin
                                shift <= tx_word;
                                tx    <= 1'b0;
                                state <= START;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
